// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: word push, break request and FIFO status.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 break_req;
  logic                 full;
  logic [LW-1:0]        level;
  logic                 busy;
  logic                 overflow;

  modport master (output wr_en, wr_data, break_req,
                  input  full, level, busy, overflow);
  modport slave  (input  wr_en, wr_data, break_req,
                  output full, level, busy, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input word FIFO, optional parity, 1/2 stop bits,
// inter-frame idle gap and break generation.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned GAP_BITS     = 0,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  uart_tx_fifo_if.slave    bus,
  output logic             TXD
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = 4;
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_BREAK
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 brk_stop, brk_n;
  logic                 txd_n;
  logic                 tick, frame_end, pop, push;
  logic [DATA_BITS-1:0] head;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level, level_n;
  logic                 fifo_full, overflow, busy;

  assign fifo_full    = (level == LW'(FIFO_DEPTH));
  assign push         = bus.wr_en & ~fifo_full;
  assign head         = mem[rd_ptr];
  assign level_n      = level + LW'(push) - LW'(pop);

  assign bus.full     = fifo_full;
  assign bus.level    = level;
  assign bus.busy     = busy;
  assign bus.overflow = overflow;

  // FIFO storage; no reset needed, contents are qualified by level
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // State, datapath and FIFO bookkeeping registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      timer    <= '0;
      cnt      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      brk_stop <= 1'b0;
      TXD      <= 1'b1;
      level    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      brk_stop <= brk_n;
      TXD      <= txd_n;
      level    <= level_n;
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      overflow <= overflow | (bus.wr_en & fifo_full);
      busy     <= (state_n != S_IDLE) || (level_n != '0);
    end
  end

  // Next-state and line value; frame_end shares the IDLE decision so
  // back-to-back frames pass through IDLE in zero time.
  always_comb begin
    state_n   = state;
    timer_n   = (timer == '0) ? '0 : timer - TW'(1);
    cnt_n     = cnt;
    shreg_n   = shreg;
    par_n     = par_bit;
    brk_n     = brk_stop;
    txd_n     = TXD;
    pop       = 1'b0;
    frame_end = 1'b0;
    tick      = (timer == '0);

    case (state)
      S_IDLE: frame_end = 1'b1;
      S_START: begin
        if (tick) begin
          state_n = S_DATA;
          timer_n = BIT_LOAD;
          cnt_n   = CW'(DATA_BITS - 1);
          txd_n   = shreg[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_n = BIT_LOAD;
          if (cnt != '0) begin
            cnt_n   = cnt - CW'(1);
            shreg_n = shreg >> 1;
            txd_n   = shreg_n[0];
          end else if (PARITY != 0) begin
            state_n = S_PARITY;
            txd_n   = par_bit;
          end else begin
            state_n = S_STOP;
            cnt_n   = CW'(STOP_BITS - 1);
            txd_n   = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_n = S_STOP;
          timer_n = BIT_LOAD;
          cnt_n   = CW'(STOP_BITS - 1);
          txd_n   = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (cnt != '0) begin
            cnt_n   = cnt - CW'(1);
            timer_n = BIT_LOAD;
          end else if (GAP_BITS > 0 && !brk_stop) begin
            state_n = S_GAP;
            cnt_n   = CW'(GAP_BITS - 1);
            timer_n = BIT_LOAD;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (cnt != '0) begin
            cnt_n   = cnt - CW'(1);
            timer_n = BIT_LOAD;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_BREAK: begin
        txd_n = 1'b0;
        if (!bus.break_req) begin
          state_n = S_STOP;
          timer_n = BIT_LOAD;
          cnt_n   = '0;
          brk_n   = 1'b1;
          txd_n   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (frame_end) begin
      state_n = S_IDLE;
      brk_n   = 1'b0;
      txd_n   = 1'b1;
      if (bus.break_req) begin
        state_n = S_BREAK;
        txd_n   = 1'b0;
      end else if (level != '0) begin
        pop     = 1'b1;
        shreg_n = head;
        par_n   = (PARITY == 1) ? ~^head : ^head;
        state_n = S_START;
        timer_n = BIT_LOAD;
        txd_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats at 4 clocks/bit, line waveform
// compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_fifo;
  localparam int unsigned CPB    = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int          BRK_ON  = 10;
  localparam int          BRK_LEN = 50;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic       wr_en_v   [3];
  logic [7:0] wr_data_v [3];
  logic       brk_v     [3];
  logic       txd_a, txd_b, txd_c;

  int n_asrt = 0;
  int n_fail = 0;
  bit exp_q[$];
  bit ovf_model[3];
  int par_cfg [3] = '{0, 2, 1};
  int stop_cfg[3] = '{1, 2, 1};
  int gap_cfg [3] = '{0, 0, 2};

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_c ();

  assign if_a.wr_en = wr_en_v[0]; assign if_a.wr_data = wr_data_v[0]; assign if_a.break_req = brk_v[0];
  assign if_b.wr_en = wr_en_v[1]; assign if_b.wr_data = wr_data_v[1]; assign if_b.break_req = brk_v[1];
  assign if_c.wr_en = wr_en_v[2]; assign if_c.wr_data = wr_data_v[2]; assign if_c.break_req = brk_v[2];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .GAP_BITS(0), .FIFO_DEPTH(DEPTH))
    dut_a (.clk(clk), .resetn(resetn), .bus(if_a.slave), .TXD(txd_a));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                 .GAP_BITS(0), .FIFO_DEPTH(DEPTH))
    dut_b (.clk(clk), .resetn(resetn), .bus(if_b.slave), .TXD(txd_b));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                 .GAP_BITS(2), .FIFO_DEPTH(DEPTH))
    dut_c (.clk(clk), .resetn(resetn), .bus(if_c.slave), .TXD(txd_c));

  function automatic logic get_txd(input int s);
    case (s) 0: return txd_a; 1: return txd_b; default: return txd_c; endcase
  endfunction
  function automatic logic [2:0] get_level(input int s);
    case (s) 0: return if_a.level; 1: return if_b.level; default: return if_c.level; endcase
  endfunction
  function automatic logic get_full(input int s);
    case (s) 0: return if_a.full; 1: return if_b.full; default: return if_c.full; endcase
  endfunction
  function automatic logic get_busy(input int s);
    case (s) 0: return if_a.busy; 1: return if_b.busy; default: return if_c.busy; endcase
  endfunction
  function automatic logic get_ovf(input int s);
    case (s) 0: return if_a.overflow; 1: return if_b.overflow; default: return if_c.overflow; endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_bits(input bit v, input int nbits);
    repeat (nbits * CPB) exp_q.push_back(v);
  endtask

  // One frame as a list of bit values: start, data LSB first, parity, stop, gap
  task automatic add_frame(input int s, input logic [7:0] d);
    int ones;
    ones = 0;
    add_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      add_bits(d[i], 1);
      if (d[i]) ones++;
    end
    if (par_cfg[s] == 2) add_bits(bit'(ones % 2), 1);
    if (par_cfg[s] == 1) add_bits(bit'((ones % 2) == 0), 1);
    add_bits(1'b1, stop_cfg[s] + gap_cfg[s]);
  endtask

  // Writes w[] on consecutive edges into an idle, empty DUT and checks the line
  task automatic run_case(input int s, input logic [7:0] w[$], input bit brk);
    logic [7:0] acc[$];
    int lvl_exp[$];
    int lvl;
    bit ok;
    lvl = 0;
    exp_q.delete();
    for (int j = 0; j < w.size(); j++) begin
      ok = (lvl < int'(DEPTH));
      if (ok) acc.push_back(w[j]);
      else    ovf_model[s] = 1'b1;
      lvl = lvl + int'(ok) - ((j == 1) ? 1 : 0);
      lvl_exp.push_back(lvl);
    end
    exp_q.push_back(1'b1);
    add_frame(s, acc[0]);
    if (brk) begin
      repeat (BRK_ON + BRK_LEN + 1 - exp_q.size()) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    end
    for (int i = 1; i < acc.size(); i++) add_frame(s, acc[i]);
    repeat (8) exp_q.push_back(1'b1);

    fork
      begin
        for (int j = 0; j < w.size(); j++) begin
          wr_en_v[s]   = 1'b1;
          wr_data_v[s] = w[j];
          @(posedge clk); #1;
          chk("level", 32'(get_level(s)), 32'(lvl_exp[j]));
          chk("full", 32'(get_full(s)), 32'(lvl_exp[j] == int'(DEPTH)));
          chk("busy_on", 32'(get_busy(s)), 32'd1);
        end
        wr_en_v[s] = 1'b0;
      end
      begin
        if (brk) begin
          repeat (BRK_ON + 1) @(posedge clk);
          #1 brk_v[s] = 1'b1;
          repeat (BRK_LEN) @(posedge clk);
          #1 brk_v[s] = 1'b0;
        end
      end
      begin
        for (int i = 0; i < exp_q.size(); i++) begin
          @(posedge clk); #1;
          chk($sformatf("txd[%0d]", i), 32'(get_txd(s)), 32'(exp_q[i]));
        end
      end
    join
    chk("busy_off", 32'(get_busy(s)), 32'd0);
    chk("level_end", 32'(get_level(s)), 32'd0);
    chk("overflow", 32'(get_ovf(s)), 32'(ovf_model[s]));
  endtask

  initial begin
    logic [7:0] wq[$];
    int s, n;
    for (int i = 0; i < 3; i++) begin
      wr_en_v[i] = 1'b0; wr_data_v[i] = '0; brk_v[i] = 1'b0; ovf_model[i] = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_txd", 32'(get_txd(i)), 32'd1);
      chk("rst_level", 32'(get_level(i)), 32'd0);
      chk("rst_full", 32'(get_full(i)), 32'd0);
      chk("rst_busy", 32'(get_busy(i)), 32'd0);
      chk("rst_ovf", 32'(get_ovf(i)), 32'd0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;

    wq.delete(); wq.push_back(8'h34);
    run_case(0, wq, 1'b0);
    wq.delete(); wq.push_back(8'h2A);
    run_case(1, wq, 1'b0);
    run_case(2, wq, 1'b0);
    wq.delete(); wq.push_back(8'h34); wq.push_back(8'h39);
    run_case(2, wq, 1'b0);
    wq.delete();
    wq.push_back(8'h34); wq.push_back(8'h2A); wq.push_back(8'h34);
    wq.push_back(8'h39); wq.push_back(8'h2F); wq.push_back(8'h30);
    run_case(0, wq, 1'b0);
    wq.delete(); wq.push_back(8'h39); wq.push_back(8'h2F);
    run_case(0, wq, 1'b1);

    for (int r = 0; r < 5; r++) begin
      s = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, DEPTH + 2));
      wq.delete();
      for (int j = 0; j < n; j++) wq.push_back(8'($urandom_range(0, 255)));
      run_case(s, wq, 1'b0);
    end

    // Reset pulse in the middle of the DATA bits of 0x39 with 3 words queued
    exp_q.delete();
    exp_q.push_back(1'b1);
    add_frame(0, 8'h39);
    wq.delete();
    wq.push_back(8'h39); wq.push_back(8'h34); wq.push_back(8'h2A); wq.push_back(8'h2F);
    for (int j = 0; j < 4; j++) begin
      wr_en_v[0] = 1'b1; wr_data_v[0] = wq[j];
      @(posedge clk); #1;
    end
    wr_en_v[0] = 1'b0;
    chk("pre_rst_level", 32'(get_level(0)), 32'd3);
    chk("pre_rst_txd3", 32'(get_txd(0)), 32'(exp_q[3]));
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_txd10", 32'(get_txd(0)), 32'(exp_q[10]));
    #1 resetn = 1'b0;
    #1;
    chk("async_txd", 32'(get_txd(0)), 32'd1);
    chk("async_level", 32'(get_level(0)), 32'd0);
    chk("async_busy", 32'(get_busy(0)), 32'd0);
    chk("async_full", 32'(get_full(0)), 32'd0);
    chk("async_ovf", 32'(get_ovf(0)), 32'd0);
    #2 resetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      chk("post_rst_txd", 32'(get_txd(0)), 32'd1);
    end
    chk("post_rst_busy", 32'(get_busy(0)), 32'd0);
    chk("post_rst_level", 32'(get_level(0)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
